// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner.
// Each channel has an input synchroniser, optional inversion, a tick-paced
// debounce counter, one-clock press/release strobes, and a long-press detector
// with optional auto-repeat.
//
// Handshake note: there is no valid/ready handshake in this block. tick is a
// single-cycle enable; every strobe output (btn_rise, btn_fall, btn_hold) is
// high for exactly one clk_100Mhz cycle and carries no backpressure.
module btn_debounce_multi #(
  parameter int N_CH          = 3,
  parameter int CNT_MAX       = 10,
  parameter int SYNC_STAGES   = 2,
  parameter int ACTIVE_LOW_IN = 0,
  parameter int HOLD_TICKS    = 500,
  parameter int REPEAT_TICKS  = 100
) (
  input  logic            clk_100Mhz,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_db,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_hold
);

  localparam int DW_RAW = $clog2(CNT_MAX + 1);
  localparam int DW     = (DW_RAW < 1) ? 1 : DW_RAW;
  localparam int HMAX   = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HW     = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DCNT_LAST = DW'(CNT_MAX - 1);
  localparam logic [HW:0]   HOLD_T    = (HW+1)'(HOLD_TICKS);
  localparam logic [HW:0]   REP_T     = (HW+1)'(REPEAT_TICKS);
  localparam logic          INV       = (ACTIVE_LOW_IN != 0);

  // Inversion happens ahead of the synchroniser so that the all-zero reset
  // value of the flops always means "released".
  logic [N_CH-1:0] w_in;
  logic [N_CH-1:0] w_sync;
  logic [N_CH-1:0] r_sync [SYNC_STAGES];

  assign w_in   = btn_raw ^ {N_CH{INV}};
  assign w_sync = r_sync[SYNC_STAGES-1];

  // Raw-input synchroniser chain, runs every clock regardless of tick.
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= w_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic          r_db;
    logic          r_rise;
    logic          r_fall;
    logic          r_hold;
    logic          r_rep;
    logic [DW-1:0] r_dcnt;
    logic [HW-1:0] r_hcnt;
    logic          w_mismatch;
    logic          w_accept;
    logic [HW:0]   w_hnext;

    // w_accept marks the tick on which a new level is taken; it also tells
    // the hold logic that a release on this tick overrides any hold strobe.
    assign w_mismatch = w_sync[g] ^ r_db;
    assign w_accept   = w_mismatch & (r_dcnt == DCNT_LAST);
    assign w_hnext    = {1'b0, r_hcnt} + {{HW{1'b0}}, 1'b1};

    // Debounce, edge strobes and long-press/repeat detection for one channel.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
        r_db   <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_hold <= 1'b0;
        r_rep  <= 1'b0;
        r_dcnt <= '0;
        r_hcnt <= '0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_hold <= 1'b0;
        if (tick) begin
          if (!w_mismatch) begin
            r_dcnt <= '0;
          end else if (w_accept) begin
            r_db   <= w_sync[g];
            r_dcnt <= '0;
            r_rise <= w_sync[g];
            r_fall <= ~w_sync[g];
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end

          // The rise tick sees r_db=0, so hold counting starts one tick later.
          if (r_db) begin
            if (w_accept) begin
              r_hcnt <= '0;
              r_rep  <= 1'b0;
            end else if (!r_rep) begin
              if (w_hnext >= HOLD_T) begin
                r_hold <= 1'b1;
                r_rep  <= 1'b1;
                r_hcnt <= '0;
              end else begin
                r_hcnt <= w_hnext[HW-1:0];
              end
            end else if (REPEAT_TICKS != 0) begin
              if (w_hnext >= REP_T) begin
                r_hold <= 1'b1;
                r_hcnt <= '0;
              end else begin
                r_hcnt <= w_hnext[HW-1:0];
              end
            end
          end
        end
      end
    end

    assign btn_db[g]   = r_db;
    assign btn_rise[g] = r_rise;
    assign btn_fall[g] = r_fall;
    assign btn_hold[g] = r_hold;
  end

endmodule
